// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and the decoded sync bundle
`timescale 1ns/1ps
package vga_timing_pkg;

    localparam int COUNT_W = 16;

    localparam logic [COUNT_W-1:0] H_ACTIVE = COUNT_W'(640);
    localparam logic [COUNT_W-1:0] H_FRONT  = COUNT_W'(16);
    localparam logic [COUNT_W-1:0] H_SYNC   = COUNT_W'(96);
    localparam logic [COUNT_W-1:0] H_BACK   = COUNT_W'(48);
    localparam logic [COUNT_W-1:0] H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam logic [COUNT_W-1:0] V_ACTIVE = COUNT_W'(480);
    localparam logic [COUNT_W-1:0] V_FRONT  = COUNT_W'(10);
    localparam logic [COUNT_W-1:0] V_SYNC   = COUNT_W'(2);
    localparam logic [COUNT_W-1:0] V_BACK   = COUNT_W'(33);
    localparam logic [COUNT_W-1:0] V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [COUNT_W-1:0] V_LAST   = V_TOTAL - COUNT_W'(1);

    // Sync windows are half-open: [START, END)
    localparam logic [COUNT_W-1:0] H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam logic [COUNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [COUNT_W-1:0] V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam logic [COUNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic               display_enable;
        logic [COUNT_W-1:0] pixel_x;
        logic [COUNT_W-1:0] pixel_y;
    } sync_out_t;

    // Blanked bundle with both syncs parked at their inactive level
    function automatic sync_out_t sync_idle(input logic active_low);
        sync_out_t s;
        s       = '0;
        s.hsync = active_low;
        s.vsync = active_low;
        return s;
    endfunction

endpackage

// File: rtl/vertical_line_counter.sv
// rtl/vertical_line_counter.sv - line counter with same-cycle look-ahead of the next line
`timescale 1ns/1ps
module vertical_line_counter
    import vga_timing_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_vertical_counter,
    output logic [COUNT_W-1:0] v_eff
);

    logic [COUNT_W-1:0] v_count;

    // v_eff already reflects this cycle's line pulse, so the line changes at h==0 with no skew
    always_comb begin
        v_eff = v_count;
        if (enable_vertical_counter) begin
            v_eff = (v_count == V_LAST) ? '0 : v_count + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_count <= '0;
        end else begin
            v_count <= v_eff;
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - registered sync/enable/coordinate decode, frame counter and protocol error flag
`timescale 1ns/1ps
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COUNT_W-1:0] horizontal_count_value,
    input  logic               enable_vertical_counter,
    output logic               hsync,
    output logic               vsync,
    output logic               display_enable,
    output logic [COUNT_W-1:0] pixel_x,
    output logic [COUNT_W-1:0] pixel_y,
    output logic               frame_start,
    output logic [7:0]         frame_count,
    output logic               timing_error
);

    logic [COUNT_W-1:0] v_eff;

    vertical_line_counter u_line_counter (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .enable_vertical_counter (enable_vertical_counter),
        .v_eff                   (v_eff)
    );

    sync_out_t sync_d;
    sync_out_t sync_q;
    logic      active;
    logic      h_in_sync;
    logic      v_in_sync;
    logic      at_origin;
    logic      protocol_violation;

    always_comb begin
        sync_d    = sync_idle(SYNC_ACTIVE_LOW);
        active    = (horizontal_count_value < H_ACTIVE) && (v_eff < V_ACTIVE);
        h_in_sync = (horizontal_count_value >= H_SYNC_START) && (horizontal_count_value < H_SYNC_END);
        v_in_sync = (v_eff >= V_SYNC_START) && (v_eff < V_SYNC_END);

        // XOR with the polarity turns "asserted" into the pin level
        sync_d.hsync          = SYNC_ACTIVE_LOW ^ h_in_sync;
        sync_d.vsync          = SYNC_ACTIVE_LOW ^ v_in_sync;
        sync_d.display_enable = active;
        if (active) begin
            sync_d.pixel_x = horizontal_count_value;
            sync_d.pixel_y = v_eff;
        end

        at_origin          = (horizontal_count_value == '0) && (v_eff == '0);
        protocol_violation = (enable_vertical_counter && (horizontal_count_value != '0))
                           || (horizontal_count_value >= H_TOTAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= sync_idle(SYNC_ACTIVE_LOW);
            frame_start  <= 1'b0;
            frame_count  <= '0;
            timing_error <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            frame_start <= at_origin;
            if (at_origin) begin
                frame_count <= frame_count + 8'd1;
            end
            if (protocol_violation) begin
                timing_error <= 1'b1;
            end
        end
    end

    assign hsync          = sync_q.hsync;
    assign vsync          = sync_q.vsync;
    assign display_enable = sync_q.display_enable;
    assign pixel_x        = sync_q.pixel_x;
    assign pixel_y        = sync_q.pixel_y;

endmodule
